// File: rtl/switch_control_unit_if.sv
// Pin-side bundle for the switch control unit: raw switches/buttons in,
// decoded algorithm, zoom level and display error flags out.
interface switch_control_unit_if;
  logic [3:0] SW;
  logic [1:0] KEY;
  logic [1:0] algorithm_select;
  logic [2:0] zoom_level;
  logic       zoom_changed;
  logic       invalid_zoom_error;
  logic       multiple_switches_error;
  logic       no_switch_selected_error;

  modport master (
    output SW, KEY,
    input  algorithm_select, zoom_level, zoom_changed,
    input  invalid_zoom_error, multiple_switches_error, no_switch_selected_error
  );

  modport slave (
    input  SW, KEY,
    output algorithm_select, zoom_level, zoom_changed,
    output invalid_zoom_error, multiple_switches_error, no_switch_selected_error
  );
endinterface

// File: rtl/switch_control_unit.sv
// Switch control unit: synchronizes and debounces the slide switches and
// pushbuttons, decodes the one-hot algorithm request, and tracks the signed
// zoom exponent (-2..+2) with direction rules per algorithm family.
module switch_control_unit #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic                  clk,
  input logic                  reset,
  switch_control_unit_if.slave bus
);
  localparam int            CW         = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
  // Buttons are active-low, so their idle stable value is 1.
  localparam logic [5:0]    STABLE_RST = 6'b11_0000;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Input vector: [5:4] = KEY, [3:0] = SW.
  logic [5:0]    raw_s;
  logic [5:0]    meta_q, sync_q;
  logic [5:0]    stable_q, stable_d;
  logic [CW-1:0] cnt_q [6];
  logic [CW-1:0] cnt_d [6];
  logic [1:0]    key_prev_q;

  logic [3:0]        sw_s;
  logic [1:0]        press_s;
  logic [2:0]        pop_s;
  logic              sw_none_s, sw_multi_s, sw_err_s;
  logic [1:0]        idx_s;
  logic              alg_change_s, zoom_req_s, accept_s;
  logic signed [3:0] cand_s;

  logic [1:0] alg_q, alg_d;
  logic [2:0] zoom_q, zoom_d;
  logic       chg_q, chg_d;
  logic       inv_q, inv_d;
  logic       multi_q, multi_d;
  logic       none_q, none_d;

  assign raw_s = {bus.KEY, bus.SW};

  // Two-flop synchronizer for every pin.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 6'b00_0000;
      sync_q <= 6'b00_0000;
    end else begin
      meta_q <= raw_s;
      sync_q <= meta_q;
    end
  end

  // Debounce next state: count consecutive disagreeing cycles, adopt the new value on the last one.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = cnt_q[i];
      if (sync_q[i] == stable_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync_q[i];
        cnt_d[i]    = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Debounce state and previous stable key levels for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stable_q   <= STABLE_RST;
      key_prev_q <= 2'b11;
      for (int i = 0; i < 6; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      stable_q   <= stable_d;
      key_prev_q <= stable_q[5:4];
      for (int i = 0; i < 6; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Switch decode and zoom decision; algorithm change outranks key events.
  always_comb begin
    sw_s       = stable_q[3:0];
    press_s    = key_prev_q & ~stable_q[5:4];
    pop_s      = popcount4(sw_s);
    sw_none_s  = (pop_s == 3'd0);
    sw_multi_s = (pop_s >= 3'd2);
    sw_err_s   = sw_none_s | sw_multi_s;

    case (sw_s)
      4'b0001: idx_s = 2'b00;
      4'b0010: idx_s = 2'b01;
      4'b0100: idx_s = 2'b10;
      4'b1000: idx_s = 2'b11;
      default: idx_s = alg_q;
    endcase

    alg_change_s = !sw_err_s && (idx_s != alg_q);
    // Simultaneous presses cancel each other.
    zoom_req_s   = !sw_err_s && !alg_change_s && (press_s[0] ^ press_s[1]);

    if (press_s[0]) begin
      cand_s = $signed({zoom_q[2], zoom_q}) + 4'sd1;
    end else begin
      cand_s = $signed({zoom_q[2], zoom_q}) - 4'sd1;
    end

    // Magnification only for NN/replication, minification only for decimation/averaging.
    accept_s = (cand_s >= -4'sd2) && (cand_s <= 4'sd2) &&
               ((cand_s == 4'sd0) ||
                ((cand_s > 4'sd0) && !alg_q[1]) ||
                ((cand_s < 4'sd0) &&  alg_q[1]));

    alg_d   = alg_q;
    zoom_d  = zoom_q;
    inv_d   = inv_q;
    chg_d   = 1'b0;
    none_d  = sw_none_s;
    multi_d = sw_multi_s;

    if (alg_change_s) begin
      alg_d  = idx_s;
      zoom_d = 3'b000;
      inv_d  = 1'b0;
      chg_d  = 1'b1;
    end else if (zoom_req_s) begin
      if (accept_s) begin
        zoom_d = cand_s[2:0];
        inv_d  = 1'b0;
        chg_d  = 1'b1;
      end else begin
        inv_d = 1'b1;
      end
    end else begin
      zoom_d = zoom_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      alg_q   <= 2'b00;
      zoom_q  <= 3'b000;
      chg_q   <= 1'b0;
      inv_q   <= 1'b0;
      multi_q <= 1'b0;
      none_q  <= 1'b0;
    end else begin
      alg_q   <= alg_d;
      zoom_q  <= zoom_d;
      chg_q   <= chg_d;
      inv_q   <= inv_d;
      multi_q <= multi_d;
      none_q  <= none_d;
    end
  end

  assign bus.algorithm_select         = alg_q;
  assign bus.zoom_level               = zoom_q;
  assign bus.zoom_changed             = chg_q;
  assign bus.invalid_zoom_error       = inv_q;
  assign bus.multiple_switches_error  = multi_q;
  assign bus.no_switch_selected_error = none_q;
endmodule

// File: tb/tb_switch_control_unit.sv
// Bench for switch_control_unit: directed scenarios plus randomized pin
// activity, checked against a sample-window reference model through a
// per-cycle expectation queue and a zoom_changed event queue.
module tb_switch_control_unit;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;

  switch_control_unit_if bus ();

  switch_control_unit #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] exp_q [$];
  logic [4:0] evt_q [$];

  // Reference model state.
  logic [5:0] m_meta, m_sync, m_stable;
  logic [5:0] m_hist [$];
  logic [1:0] m_pend;
  int         m_alg, m_zoom;
  logic       m_inv, m_multi, m_none, m_chg;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] dut_vec();
    return {bus.algorithm_select, bus.zoom_level, bus.zoom_changed,
            bus.invalid_zoom_error, bus.multiple_switches_error,
            bus.no_switch_selected_error};
  endfunction

  // Behavioural model of one clock edge, using the pins as currently driven.
  task automatic model_edge();
    int         pc, idx, cand;
    logic [1:0] ev;
    logic [5:0] old;
    bit         opp;
    if (!reset) begin
      m_meta = 6'b0; m_sync = 6'b0; m_stable = 6'b110000;
      m_hist.delete(); m_pend = 2'b00;
      m_alg = 0; m_zoom = 0;
      m_inv = 1'b0; m_multi = 1'b0; m_none = 1'b0; m_chg = 1'b0;
    end else begin
      pc = $countones(m_stable[3:0]);
      ev = m_pend;
      m_none  = (pc == 0);
      m_multi = (pc > 1);
      m_chg   = 1'b0;
      if (pc == 1) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (m_stable[i]) idx = i;
        if (idx != m_alg) begin
          m_alg = idx; m_zoom = 0; m_inv = 1'b0; m_chg = 1'b1;
        end else if (ev == 2'b01 || ev == 2'b10) begin
          cand = m_zoom + (ev[0] ? 1 : -1);
          if (cand >= -2 && cand <= 2 &&
              (cand == 0 || (cand > 0 && m_alg < 2) || (cand < 0 && m_alg >= 2))) begin
            m_zoom = cand; m_inv = 1'b0; m_chg = 1'b1;
          end else begin
            m_inv = 1'b1;
          end
        end
      end
      // A stable bit flips once the last D synchronized samples all oppose it.
      m_hist.push_back(m_sync);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      old = m_stable;
      if (m_hist.size() == D) begin
        for (int b = 0; b < 6; b++) begin
          opp = 1'b1;
          foreach (m_hist[k]) if (m_hist[k][b] == old[b]) opp = 1'b0;
          if (opp) m_stable[b] = ~old[b];
        end
      end
      m_pend = old[5:4] & ~m_stable[5:4];
      m_sync = m_meta;
      m_meta = {bus.KEY, bus.SW};
    end
    exp_q.push_back({2'(m_alg), 3'(m_zoom), m_chg, m_inv, m_multi, m_none});
    if (m_chg) evt_q.push_back({2'(m_alg), 3'(m_zoom)});
  endtask

  // Monitor: per-cycle output comparison plus zoom_changed event scoreboard.
  always @(negedge clk) begin
    logic [8:0] e;
    logic [4:0] ev;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle_outputs", dut_vec(), e);
    end
    if (bus.zoom_changed === 1'b1) begin
      if (evt_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pulse_unexpected: actual=%h expected=none at %0t",
                 {bus.algorithm_select, bus.zoom_level}, $time);
      end else begin
        ev = evt_q.pop_front();
        check("pulse_value", {4'b0000, bus.algorithm_select, bus.zoom_level}, {4'b0000, ev});
      end
    end
  end

  task automatic step(input logic [3:0] sw, input logic [1:0] key, input logic rst);
    reset   = rst;
    bus.SW  = sw;
    bus.KEY = key;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] sw, input logic [1:0] key, input int n);
    repeat (n) step(sw, key, 1'b1);
  endtask

  task automatic press(input logic [3:0] sw, input logic [1:0] key);
    hold(sw, key, 7);
    hold(sw, 2'b11, 7);
  endtask

  initial begin
    int         pulses;
    logic [3:0] sw;
    logic [1:0] key;

    // Reset default.
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 2'b11, 1'b0);
      check("reset_outputs", dut_vec(), 9'h000);
    end
    step(4'b0000, 2'b11, 1'b1);
    check("none_after_release", {8'h00, bus.no_switch_selected_error}, 9'd1);
    hold(4'b0010, 2'b11, 6);
    check("alg_before_qualify", {7'h00, bus.algorithm_select}, 9'd0);
    hold(4'b0010, 2'b11, 1);
    check("alg_select_01", dut_vec(), {2'b01, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0});

    // Debounce.
    hold(4'b0001, 2'b11, 8);
    hold(4'b0011, 2'b11, 3);
    hold(4'b0001, 2'b11, 8);
    check("glitch_no_multi", {8'h00, bus.multiple_switches_error}, 9'd0);
    hold(4'b0011, 2'b11, 6);
    check("multi_before_qualify", {8'h00, bus.multiple_switches_error}, 9'd0);
    hold(4'b0011, 2'b11, 1);
    check("multi_set_alg_holds", dut_vec(), {2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0});

    // Zoom in range.
    hold(4'b0001, 2'b11, 8);
    press(4'b0001, 2'b10);
    check("zoom_in_1", {6'h00, bus.zoom_level}, 9'd1);
    press(4'b0001, 2'b10);
    check("zoom_in_2", {6'h00, bus.zoom_level}, 9'd2);
    press(4'b0001, 2'b10);
    check("zoom_in_limit", dut_vec(), {2'b00, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0});
    press(4'b0001, 2'b01);
    check("zoom_out_to_1", dut_vec(), {2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0});

    // Direction mismatch.
    hold(4'b0100, 2'b11, 8);
    check("alg_10_reset_zoom", dut_vec(), {2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0});
    press(4'b0100, 2'b10);
    check("dir_mismatch", dut_vec(), {2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0});
    press(4'b0100, 2'b01);
    press(4'b0100, 2'b01);
    check("zoom_out_minus2", dut_vec(), {2'b10, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0});

    // Algorithm change.
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(4'b1000, 2'b11, 1'b1);
      if (bus.zoom_changed === 1'b1) pulses++;
    end
    check("alg_change_pulses", 9'(pulses), 9'd1);
    check("alg_change_state", dut_vec(), {2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0});

    // Simultaneous keys and keys during a switch error.
    press(4'b1000, 2'b01);
    press(4'b1000, 2'b00);
    check("both_keys_dropped", dut_vec(), {2'b11, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0});
    press(4'b1000, 2'b01);
    press(4'b1000, 2'b01);
    check("zoom_out_reject", dut_vec(), {2'b11, 3'b110, 1'b0, 1'b1, 1'b0, 1'b0});
    hold(4'b0000, 2'b11, 8);
    press(4'b0000, 2'b10);
    check("key_during_error", dut_vec(), {2'b11, 3'b110, 1'b0, 1'b1, 1'b0, 1'b1});

    // Reset mid-qualification.
    hold(4'b0010, 2'b11, 4);
    step(4'b0010, 2'b11, 1'b0);
    hold(4'b0010, 2'b11, 6);
    check("requalify_pending", dut_vec(), {2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1});
    hold(4'b0010, 2'b11, 1);
    check("requalify_done", {7'h00, bus.algorithm_select}, 9'd1);

    // Randomized activity.
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        step(4'b0001, 2'b11, 1'b0);
      end else begin
        if ($urandom_range(0, 3) != 0) sw = 4'b0001 << $urandom_range(0, 3);
        else                           sw = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 0) key = 2'b11;
        else                           key = 2'($urandom_range(0, 3));
        hold(sw, key, $urandom_range(1, 10));
      end
    end
    hold(4'b0001, 2'b11, 10);

    #1;
    check("event_queue_drained", 9'(evt_q.size()), 9'd0);
    check("cycle_queue_drained", 9'(exp_q.size()), 9'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/switch_control_unit.md
# switch_control_unit

Front-end input controller for the image-scaling design. It synchronizes and debounces the board slide switches and pushbuttons. It decodes the one-hot algorithm switches into `algorithm_select` plus the three switch/zoom error flags consumed by the scrolling text display, and it maintains the current zoom level. It sits between the board I/O pins and both the display block and the scaling engine.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive cycles an input must hold a new synchronized value before it is accepted (20 ms at 50 MHz). Minimum 2.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-low reset.
- `SW`  in  4: raw slide switches, one-hot algorithm request. SW[0] selects NEAREST NEIGHBOR (00), SW[1] PIXEL REPLICATION (01), SW[2] DECIMATION (10), SW[3] BLOCK AVERAGING (11).
- `KEY`  in  2: raw pushbuttons, active-low. KEY[0] is zoom in; KEY[1] is zoom out.
- `algorithm_select`  out  2: last validly selected algorithm.
- `zoom_level`  out  3: signed two's-complement zoom exponent in the range -2..+2 (0.25x..4x).
- `zoom_changed`  out  1: one-cycle pulse whenever `algorithm_select` or `zoom_level` changes.
- `invalid_zoom_error`  out  1: the last zoom request was rejected.
- `multiple_switches_error`  out  1: two or more debounced SW bits are high.
- `no_switch_selected_error`  out  1: no debounced SW bit is high.

## Operation
- **Input path.** Each of the 6 inputs passes through a 2-flop synchronizer, then a per-input debounce counter.
  - The counter clears whenever the synchronized value equals the stable value.
  - The counter increments while the two values differ.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, the stable value takes the synchronized value and the counter clears.
- **Key events.** A press event is a 1->0 transition of a stable KEY bit. It lasts one cycle.
- **Switch decode** (registered, from the stable SW value):
  - popcount 0: `no_switch_selected_error`=1, `multiple_switches_error`=0.
  - popcount >=2: `multiple_switches_error`=1, `no_switch_selected_error`=0.
  - popcount 1: both switch errors are 0.
  - If the decoded index differs from `algorithm_select`: load the index, set `zoom_level`<=0, set `invalid_zoom_error`<=0, pulse `zoom_changed`.
  - While a switch error is active, `algorithm_select` and `zoom_level` hold.
- **Zoom request handling.** Requests are processed only when both switch errors are 0 and no algorithm change occurs in the same cycle.
  - The candidate level is `zoom_level`+1 for zoom in, or -1 for zoom out.
  - Accept if the candidate is in -2..+2 and one of these holds:
    - the candidate is 0;
    - the candidate is >0 and `algorithm_select` is 00 or 01;
    - the candidate is <0 and `algorithm_select` is 10 or 11.
  - On accept: update `zoom_level`, set `invalid_zoom_error`<=0, pulse `zoom_changed`.
  - On reject: `zoom_level` holds, `invalid_zoom_error`<=1.
- **Precedence and simultaneous events.**
  - An algorithm change wins over a key event in the same cycle; the key event is dropped.
  - Both keys pressed in the same cycle: both are dropped with no state or flag change.
  - Key events that occur while a switch error is active are dropped, not queued.
  - `invalid_zoom_error` is sticky until an accepted request or an algorithm change.

## Timing
- **Reset.** Reset is sampled on the clk edge while `reset`=0. It returns every output to 0: `algorithm_select`=00, `zoom_level`=000, all flags 0, no pulse. Internal state resets as follows:
  - synchronizers and stable SW bits = 0; stable KEY bits = 1;
  - debounce counters = 0.
- **After reset.** With all switches off, `no_switch_selected_error` rises 1 cycle after reset deasserts.
- **Reset mid-debounce.** Reset during an in-progress debounce discards the partial count. The pending change must then re-qualify for a full DEBOUNCE_CYCLES.
- **Latency.** A clean input change at the pin reaches the outputs 2 (sync) + DEBOUNCE_CYCLES (qualify) + 1 (decode register) cycles later.
- **Glitch rejection.**
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no output change.
  - A bounce that returns to the stable value restarts the count from 0.
- **Pulse width.** `zoom_changed` is exactly 1 cycle wide and coincides with the cycle in which the new `algorithm_select`/`zoom_level` value first appears.
- **Error flags.** The error flags update in the same cycle as the decision that causes them.

## Test plan
Run with DEBOUNCE_CYCLES=4.
- **Reset default:** reset low for 3 cycles with SW=0000 and KEY=11, then release -> all outputs 0 during reset, `no_switch_selected_error`=1 one cycle after release; then SW=0010 -> after 7 cycles `algorithm_select`=01, errors 0, one `zoom_changed` pulse.
- **Debounce:** SW toggles 0001->0011 for 3 cycles and back -> `multiple_switches_error` stays 0. Hold 0011 -> `multiple_switches_error`=1 at cycle 7 while `algorithm_select` holds 00.
- **Zoom in range:** SW=0001, press KEY[0] three times -> `zoom_level` goes 1, 2, then stays 2 with `invalid_zoom_error`=1. Press KEY[1] -> level 1, error 0.
- **Direction mismatch:** SW=0100 at level 0, press KEY[0] -> level stays 0 and `invalid_zoom_error`=1. Press KEY[1] twice -> levels -1, -2 (3'b110), error 0.
- **Algorithm change:** algorithm 10 at level -2, switch to SW=1000 -> `algorithm_select`=11, `zoom_level`=0, `invalid_zoom_error`=0, a single `zoom_changed` pulse.
- **Simultaneous and during error:**
  - Both keys pressed the same cycle -> no change to any output.
  - Key press while SW=0000 -> `zoom_level` holds and `invalid_zoom_error` holds.
  - Reset asserted mid-qualification -> after release, the pending change needs the full 4 cycles again.
